// File: rtl/div_pkg.sv
// Shared definitions for the sequential 64/32 restoring divider.
package div_pkg;
  localparam int DW = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2*DW-1:0] DIV0_QUOTIENT = {(2*DW){1'b1}};
endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int W = div_pkg::DW
) (
  input  logic [W:0]   prem,
  input  logic         q_msb,
  input  logic [W-1:0] divisor,
  output logic [W:0]   prem_next,
  output logic         q_bit
);
  logic [W:0] r_s;
  logic [W:0] d_s;
  logic       unused_prem_msb_s;

  // The partial remainder stays below the divisor, so its top bit never feeds the shift.
  assign unused_prem_msb_s = prem[W];

  // Trial subtraction, widened by one bit so the shifted remainder cannot overflow.
  always_comb begin
    r_s = {prem[W-1:0], q_msb};
    d_s = {1'b0, divisor};
    if (r_s >= d_s) begin
      prem_next = r_s - d_s;
      q_bit     = 1'b1;
    end else begin
      prem_next = r_s;
      q_bit     = 1'b0;
    end
  end
endmodule

// File: rtl/seq_div_64x32.sv
// Sequential unsigned divider, 2*DW-bit dividend by DW-bit divisor, one quotient bit per clock.
module seq_div_64x32 #(
  parameter int DW = div_pkg::DW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2*DW-1:0] dividend,
  input  logic [DW-1:0]   divisor,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*DW-1:0] quotient,
  output logic [DW-1:0]   remainder,
  output logic            div_by_zero
);
  import div_pkg::*;

  localparam int            CW       = $clog2(2*DW);
  localparam logic [CW-1:0] CNT_LOAD = CW'(2*DW-1);

  state_t            state_r;
  state_t            state_s;
  logic [2*DW-1:0]   q_r;
  logic [DW:0]       prem_r;
  logic [DW-1:0]     divisor_r;
  logic [CW-1:0]     count_r;
  logic              div_by_zero_r;
  logic [DW:0]       prem_next_s;
  logic              q_bit_s;

  div_step #(.W(DW)) u_step (
    .prem      (prem_r),
    .q_msb     (q_r[2*DW-1]),
    .divisor   (divisor_r),
    .prem_next (prem_next_s),
    .q_bit     (q_bit_s)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; a zero divisor skips the iteration phase entirely.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_s = (divisor == '0) ? DONE : CALC;
        end else begin
          state_s = IDLE;
        end
      end
      CALC: begin
        if (count_r == '0) begin
          state_s = DONE;
        end else begin
          state_s = CALC;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Datapath: operand capture, per-cycle iteration, result held through DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r           <= '0;
      prem_r        <= '0;
      divisor_r     <= '0;
      count_r       <= '0;
      div_by_zero_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            divisor_r <= divisor;
            count_r   <= CNT_LOAD;
            prem_r    <= '0;
            if (divisor == '0) begin
              q_r           <= DIV0_QUOTIENT;
              div_by_zero_r <= 1'b1;
            end else begin
              q_r           <= dividend;
              div_by_zero_r <= 1'b0;
            end
          end
        end
        CALC: begin
          prem_r <= prem_next_s;
          q_r    <= {q_r[2*DW-2:0], q_bit_s};
          if (count_r != '0) begin
            count_r <= count_r - CW'(1);
          end
        end
        DONE: begin
          q_r <= q_r;
        end
        default: begin
          count_r <= '0;
        end
      endcase
    end
  end

  assign in_ready    = (state_r == IDLE);
  assign out_valid   = (state_r == DONE);
  assign quotient    = q_r;
  assign remainder   = prem_r[DW-1:0];
  assign div_by_zero = div_by_zero_r;
endmodule

// File: tb/tb_seq_div_64x32.sv
// Scoreboard-driven bench for seq_div_64x32: results, latency, backpressure and reset abort.
module tb_seq_div_64x32;
  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] dividend;
  logic [31:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  typedef struct {
    logic [63:0] q;
    logic [31:0] r;
    logic        dz;
  } exp_t;

  exp_t sb[$];
  int   n_checks;
  int   n_fail;

  seq_div_64x32 dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents one operand pair, pushes the reference result, returns just after the accepting edge.
  task automatic drive_op(input logic [63:0] a, input logic [31:0] b, output longint t_acc);
    exp_t e;
    int   guard;
    guard = 0;
    t_acc = 0;
    @(negedge clk);
    while (!in_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    n_checks++;
    if (!in_ready) begin
      n_fail++;
      $display("FAIL drive_in_ready_timeout: in_ready=%0b required 1", in_ready);
      return;
    end
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    if (b == 32'd0) begin
      e.q  = {64{1'b1}};
      e.r  = 32'd0;
      e.dz = 1'b1;
    end else begin
      e.q  = a / {32'd0, b};
      e.r  = 32'(a % {32'd0, b});
      e.dz = 1'b0;
    end
    sb.push_back(e);
    @(posedge clk);
    t_acc = $time;
    #1 in_valid = 1'b0;
  endtask

  // Counts clock edges after acceptance until out_valid is seen (bounded).
  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    n_checks++;
    if (quotient !== 64'd0) begin n_fail++; $display("FAIL reset_quotient: got %h want 0", quotient); end
    n_checks++;
    if (remainder !== 32'd0) begin n_fail++; $display("FAIL reset_remainder: got %h want 0", remainder); end
    n_checks++;
    if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset_div_by_zero: got %0b want 0", div_by_zero); end
  endtask

  task automatic test_results();
    logic [63:0] a_tab[7];
    logic [31:0] b_tab[7];
    longint      t;
    int          lat;
    exp_t        e;
    a_tab[0] = 64'd30;                 b_tab[0] = 32'd6;
    a_tab[1] = 64'd100;                b_tab[1] = 32'd7;
    a_tab[2] = 64'h00000000FFFE0001;   b_tab[2] = 32'd65535;
    a_tab[3] = 64'hFFFFFFFFFFFFFFFF;   b_tab[3] = 32'd1;
    a_tab[4] = {$urandom, $urandom};   b_tab[4] = $urandom | 32'd1;
    a_tab[5] = {$urandom, $urandom};   b_tab[5] = ($urandom >> 16) | 32'd1;
    a_tab[6] = {32'd0, $urandom};      b_tab[6] = 32'hFFFFFFFF;
    for (int i = 0; i < 7; i++) begin
      drive_op(a_tab[i], b_tab[i], t);
      wait_out(lat);
      n_checks++;
      if (lat !== 64) begin n_fail++; $display("FAIL res%0d_latency: got %0d want 64", i, lat); end
      if (sb.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL res%0d_scoreboard_empty: size %0d want 1", i, sb.size());
      end else begin
        e = sb.pop_front();
        n_checks++;
        if (quotient !== e.q) begin n_fail++; $display("FAIL res%0d_quotient: got %h want %h", i, quotient, e.q); end
        n_checks++;
        if (remainder !== e.r) begin n_fail++; $display("FAIL res%0d_remainder: got %h want %h", i, remainder, e.r); end
        n_checks++;
        if (div_by_zero !== e.dz) begin n_fail++; $display("FAIL res%0d_div_by_zero: got %0b want %0b", i, div_by_zero, e.dz); end
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL res%0d_release: in_ready=%0b out_valid=%0b want 1/0", i, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_div_zero();
    longint t;
    int     lat;
    exp_t   e;
    drive_op(64'd1000, 32'd0, t);
    wait_out(lat);
    // out_valid is already high in the first cycle following the accepting edge.
    n_checks++;
    if (lat !== 0) begin n_fail++; $display("FAIL div0_latency: extra edges %0d want 0", lat); end
    e = sb.pop_front();
    n_checks++;
    if (quotient !== e.q) begin n_fail++; $display("FAIL div0_quotient: got %h want %h", quotient, e.q); end
    n_checks++;
    if (remainder !== e.r) begin n_fail++; $display("FAIL div0_remainder: got %h want %h", remainder, e.r); end
    n_checks++;
    if (div_by_zero !== 1'b1) begin n_fail++; $display("FAIL div0_flag: got %0b want 1", div_by_zero); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    longint t;
    int     lat;
    exp_t   e;
    out_ready = 1'b0;
    drive_op(64'd123456789012, 32'd1000, t);
    wait_out(lat);
    e = sb.pop_front();
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        dividend = 64'd77;
        divisor  = 32'd7;
        in_valid = 1'b1;
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp%0d_handshake: out_valid=%0b in_ready=%0b want 1/0", i, out_valid, in_ready);
      end
      n_checks++;
      if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.dz) begin
        n_fail++;
        $display("FAIL bp%0d_hold: got %h/%h/%0b want %h/%h/%0b", i, quotient, remainder, div_by_zero, e.q, e.r, e.dz);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: in_ready=%0b out_valid=%0b want 1/0", in_ready, out_valid);
    end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_ignored_pulse: out_valid=%0b in_ready=%0b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    longint t;
    int     lat;
    exp_t   e;
    drive_op(64'd5000, 32'd3, t);
    repeat (20) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    sb.delete();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_handshake: out_valid=%0b in_ready=%0b want 0/1", out_valid, in_ready);
    end
    n_checks++;
    if (quotient !== 64'd0) begin n_fail++; $display("FAIL rstmid_quotient: got %h want 0", quotient); end
    @(negedge clk);
    rst = 1'b0;
    drive_op(64'd255, 32'd250, t);
    wait_out(lat);
    n_checks++;
    if (lat !== 64) begin n_fail++; $display("FAIL rstmid_latency: got %0d want 64", lat); end
    e = sb.pop_front();
    n_checks++;
    if (quotient !== 64'd1 || e.q !== 64'd1) begin n_fail++; $display("FAIL rstmid_quotient_after: got %h want 1", quotient); end
    n_checks++;
    if (remainder !== 32'd5) begin n_fail++; $display("FAIL rstmid_remainder_after: got %h want 5", remainder); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    longint t0;
    longint t1;
    int     lat;
    exp_t   e;
    drive_op(64'd987654321, 32'd12345, t0);
    wait_out(lat);
    e = sb.pop_front();
    n_checks++;
    if (quotient !== e.q || remainder !== e.r) begin
      n_fail++;
      $display("FAIL b2b_first: got %h/%h want %h/%h", quotient, remainder, e.q, e.r);
    end
    drive_op(64'hDEADBEEFCAFEF00D, 32'h0000BEEF, t1);
    n_checks++;
    if (t1 - t0 !== 64'd660) begin n_fail++; $display("FAIL b2b_interval: got %0d ns want 660", t1 - t0); end
    wait_out(lat);
    e = sb.pop_front();
    n_checks++;
    if (quotient !== e.q || remainder !== e.r) begin
      n_fail++;
      $display("FAIL b2b_second: got %h/%h want %h/%h", quotient, remainder, e.q, e.r);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    dividend  = 64'd0;
    divisor   = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    test_results();
    test_div_zero();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
